audio_player: RTL and testbench

Streaming reader for the 8-bit audio sample ROM. On a play command it walks a clip of `length` bytes from `start_addr`, absorbs the ROM's one-cycle read latency, converts each byte to 16-bit signed PCM, and presents it on a valid/ready stream toward the codec output path. Each ROM byte is held for `REPEAT` accepted transfers, which turns the ROM rate into the codec rate (8 kHz to 48 kHz with `REPEAT`=6). Sits between the game-logic control registers and the audio codec interface, paired one-to-one with the sample ROM at the audio top level.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_player.sv | 156 +++++++++++++++
 tb/tb_audio_player.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio sample streaming path.
//   ADDR_W          - sample ROM address width
//   SAMPLE_W        - PCM sample width toward the codec
//   player_state_t  - audio_player FSM states
//   to_pcm16()      - 8-bit offset-binary ROM byte -> 16-bit signed PCM
package audio_pkg;

  localparam int ADDR_W   = 18;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT
  } player_state_t;

  // Flipping the MSB turns offset-binary into two's complement; the byte
  // becomes the upper half of the sample (x256).
  function automatic logic [SAMPLE_W-1:0] to_pcm16(input logic [7:0] i_byte);
    return {i_byte ^ 8'h80, 8'h00};
  endfunction

endpackage

// File: rtl/audio_player.sv
// audio_player: streams a clip of bytes out of the sample ROM, converts each
// byte to 16-bit signed PCM and presents it REPEAT times on a valid/ready
// stream (ROM rate -> codec rate).
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_play, i_stop        start / abort strobes
//   i_loop                replay clip indefinitely (sampled with i_play)
//   i_start_addr          first byte of the clip (sampled with i_play)
//   i_length              clip length in bytes (sampled with i_play)
//   o_busy, o_done        clip in progress / completion pulse
//   o_rom_addr, i_rom_q   ROM address (registered) and data (1-cycle latency)
//   o_out_sample          signed PCM sample
//   o_out_valid           sample available
//   i_out_ready           downstream accepts
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no clip; waiting for play
// S_ISSUE   | rom_addr holds the current byte address
// S_CAPTURE | ROM data valid; convert and register the sample
// S_PRESENT | out_valid high; count REPEAT handshakes for this byte
module audio_player
  import audio_pkg::*;
#(
  parameter int ADDR_W = audio_pkg::ADDR_W,
  parameter int DEPTH  = 'h24000,
  parameter int REPEAT = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_play,
  input  logic                i_stop,
  input  logic                i_loop,
  input  logic [ADDR_W-1:0]   i_start_addr,
  input  logic [ADDR_W-1:0]   i_length,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_rom_addr,
  input  logic [7:0]          i_rom_q,
  output logic [SAMPLE_W-1:0] o_out_sample,
  output logic                o_out_valid,
  input  logic                i_out_ready
);

  localparam int REP_W = $clog2(REPEAT + 1);

  player_state_t       r_state;
  player_state_t       w_next_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]   r_start;
  logic [ADDR_W-1:0]   r_len;
  logic                r_loop;
  logic [REP_W-1:0]    r_rep_cnt;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_done;

  logic                w_start;
  logic                w_hs;
  logic                w_last_rep;
  logic                w_done_next;
  logic [ADDR_W-1:0]   w_next_addr;

  assign w_start     = i_play && !i_stop && (i_length != '0);
  assign w_hs        = (r_state == S_PRESENT) && i_out_ready;
  assign w_last_rep  = w_hs && (r_rep_cnt == REP_W'(1));
  assign w_next_addr = (r_cur_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_cur_addr + 1'b1;

  always_comb begin
    w_next_state = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start)
          w_next_state = S_ISSUE;
        else if (i_play && !i_stop)
          w_done_next = 1'b1;  // zero-length clip completes immediately
      end
      S_ISSUE:   w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_PRESENT;
      S_PRESENT: begin
        if (w_last_rep) begin
          if ((r_remaining > ADDR_W'(1)) || r_loop) begin
            w_next_state = S_ISSUE;
          end else begin
            w_next_state = S_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // stop overrides everything, including a final handshake
    if (i_stop) begin
      w_next_state = S_IDLE;
      w_done_next  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_start     <= '0;
      r_len       <= '0;
      r_loop      <= 1'b0;
      r_rep_cnt   <= '0;
      r_sample    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_start     <= i_start_addr;
            r_len       <= i_length;
            r_loop      <= i_loop;
            r_cur_addr  <= i_start_addr;
            r_remaining <= i_length;
          end
        end
        S_CAPTURE: begin
          r_sample  <= to_pcm16(i_rom_q);
          r_rep_cnt <= REP_W'(REPEAT);
        end
        S_PRESENT: begin
          if (w_hs) begin
            r_rep_cnt <= r_rep_cnt - 1'b1;
            if (w_last_rep) begin
              if (r_remaining > ADDR_W'(1)) begin
                r_cur_addr  <= w_next_addr;
                r_remaining <= r_remaining - 1'b1;
              end else if (r_loop) begin
                r_cur_addr  <= r_start;
                r_remaining <= r_len;
              end
            end
          end
        end
        default: ;
      endcase
      if (w_next_state == S_IDLE)
        r_sample <= '0;
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_out_valid  = (r_state == S_PRESENT);
  assign o_done       = r_done;
  assign o_rom_addr   = r_cur_addr;
  assign o_out_sample = r_sample;

endmodule

// File: tb/tb_audio_player.sv
module tb_audio_player;

  localparam int DEPTH_TB = 'h24000;
  localparam int REP      = 6;

  logic        clk = 1'b0;
  logic        reset, play, stop, loop_i, out_ready;
  logic [17:0] start_addr, length;

  logic [17:0] rom_addr1, rom_addr6;
  logic [7:0]  rom_q1, rom_q6;
  logic        busy1, busy6, done1, done6, valid1, valid6;
  logic [15:0] sample1, sample6;

  logic [7:0]  rom_mem [0:DEPTH_TB-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q1 <= rom_mem[rom_addr1];
    rom_q6 <= rom_mem[rom_addr6];
  end

  audio_player #(.REPEAT(1)) u1 (
    .i_clk(clk), .i_reset(reset), .i_play(play), .i_stop(stop), .i_loop(loop_i),
    .i_start_addr(start_addr), .i_length(length), .o_busy(busy1), .o_done(done1),
    .o_rom_addr(rom_addr1), .i_rom_q(rom_q1), .o_out_sample(sample1),
    .o_out_valid(valid1), .i_out_ready(out_ready)
  );

  audio_player #(.REPEAT(REP)) u6 (
    .i_clk(clk), .i_reset(reset), .i_play(play), .i_stop(stop), .i_loop(loop_i),
    .i_start_addr(start_addr), .i_length(length), .o_busy(busy6), .o_done(done6),
    .o_rom_addr(rom_addr6), .i_rom_q(rom_q6), .o_out_sample(sample6),
    .o_out_valid(valid6), .i_out_ready(out_ready)
  );

  // Reference conversion: offset-binary byte minus 128, scaled by 256.
  function automatic logic [15:0] pcm(input logic [7:0] b);
    int v;
    v = (int'(b) - 128) * 256;
    return v[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    play = 1'b0; stop = 1'b1; out_ready = 1'b0;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0; stop = 1'b0; loop_i = 1'b0; out_ready = 1'b0;
    start_addr = '0; length = '0;
    repeat (3) step();
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy6); end
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done6); end
    n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid6); end
    n_cmp++; if (sample6 !== 16'h0) begin n_bad++; $display("FAIL reset_sample: got %h want 0000", sample6); end
    n_cmp++; if (rom_addr6 !== 18'h0) begin n_bad++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr6); end
    reset = 1'b0;
    step();
  endtask

  // REPEAT=1 instance: byte k is presented in cycle 3+3k, done one cycle after the last.
  task automatic test_byte_timing();
    logic        exp_v, exp_d, exp_b;
    logic [15:0] exp_s;
    rom_mem[18'h100] = 8'h80; rom_mem[18'h101] = 8'hFF; rom_mem[18'h102] = 8'h00;
    quiesce();
    play = 1'b1; start_addr = 18'h100; length = 18'd3; loop_i = 1'b0; out_ready = 1'b1;
    step();
    play = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp_v = (c == 3) || (c == 6) || (c == 9);
      exp_d = (c == 10);
      exp_b = (c <= 9);
      n_cmp++; if (valid1 !== exp_v) begin n_bad++; $display("FAIL timing_valid c%0d: got %b want %b", c, valid1, exp_v); end
      n_cmp++; if (done1 !== exp_d) begin n_bad++; $display("FAIL timing_done c%0d: got %b want %b", c, done1, exp_d); end
      n_cmp++; if (busy1 !== exp_b) begin n_bad++; $display("FAIL timing_busy c%0d: got %b want %b", c, busy1, exp_b); end
      if (exp_v) begin
        exp_s = pcm(rom_mem[18'h100 + 18'((c - 3) / 3)]);
        n_cmp++; if (sample1 !== exp_s) begin n_bad++; $display("FAIL timing_sample c%0d: got %h want %h", c, sample1, exp_s); end
      end
      step();
    end
  endtask

  // Scoreboard over the REPEAT=6 instance: the accepted stream must be every
  // clip byte (addresses wrap at DEPTH) repeated REP times, with two bubble
  // cycles before each byte, then a single done pulse.
  // mode 0: ready always high, 1: toggling, 2: random.
  task automatic run_clip(input logic [17:0] st, input logic [17:0] ln, input int mode);
    int          total, h, bubble, cyc, b;
    logic        rdy, tog, stall;
    logic [15:0] prev_s, exp_s;
    logic [17:0] exp_a;
    total = int'(ln) * REP; h = 0; cyc = 0; tog = 1'b1; stall = 1'b0; prev_s = '0;
    play = 1'b1; start_addr = st; length = ln; loop_i = 1'b0; out_ready = 1'b0;
    step();
    play = 1'b0;
    n_cmp++; if (busy6 !== 1'b1) begin n_bad++; $display("FAIL clip_busy_start: got %b want 1", busy6); end
    n_cmp++; if (rom_addr6 !== st) begin n_bad++; $display("FAIL clip_rom_addr_start: got %h want %h", rom_addr6, st); end
    bubble = 2;
    while (h < total && cyc < 40 * total + 40) begin
      if (bubble > 0) begin
        n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL clip_bubble h%0d: got valid %b want 0", h, valid6); end
        bubble--;
      end else begin
        n_cmp++; if (valid6 !== 1'b1) begin n_bad++; $display("FAIL clip_valid h%0d: got %b want 1", h, valid6); end
        b = h / REP;
        exp_a = 18'((int'(st) + b) % DEPTH_TB);
        exp_s = pcm(rom_mem[exp_a]);
        n_cmp++; if (rom_addr6 !== exp_a) begin n_bad++; $display("FAIL clip_rom_addr h%0d: got %h want %h", h, rom_addr6, exp_a); end
        n_cmp++; if (sample6 !== exp_s) begin n_bad++; $display("FAIL clip_sample h%0d: got %h want %h", h, sample6, exp_s); end
        if (stall) begin
          n_cmp++; if (sample6 !== prev_s) begin n_bad++; $display("FAIL clip_stall_hold h%0d: got %h want %h", h, sample6, prev_s); end
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = tog;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      out_ready = rdy;
      stall = valid6 && !rdy;
      prev_s = sample6;
      if (valid6 && rdy) begin
        h++;
        if ((h % REP) == 0 && h < total) bubble = 2;
      end
      step();
      cyc++;
    end
    if (h < total) begin
      n_cmp++; n_bad++;
      $display("FAIL clip_timeout: got %0d handshakes want %0d", h, total);
    end
    out_ready = 1'b0;
    n_cmp++; if (done6 !== 1'b1) begin n_bad++; $display("FAIL clip_done: got %b want 1", done6); end
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL clip_busy_end: got %b want 0", busy6); end
    n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL clip_valid_end: got %b want 0", valid6); end
    n_cmp++; if (sample6 !== 16'h0) begin n_bad++; $display("FAIL clip_sample_end: got %h want 0000", sample6); end
    step();
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL clip_done_width: got %b want 0", done6); end
  endtask

  task automatic test_repeat_backpressure();
    quiesce();
    run_clip(18'($urandom_range(0, DEPTH_TB - 8)), 18'd3, 1);
  endtask

  task automatic test_random_clips();
    for (int k = 0; k < 4; k++) begin
      quiesce();
      run_clip(18'($urandom_range(0, DEPTH_TB - 1)), 18'($urandom_range(1, 5)), 2);
    end
  endtask

  task automatic test_wrap();
    quiesce();
    run_clip(18'h23FFF, 18'd2, 0);
  endtask

  task automatic test_loop();
    int          nb, cyc;
    logic        prevv;
    logic [17:0] exp_a;
    quiesce();
    play = 1'b1; start_addr = 18'h10; length = 18'd2; loop_i = 1'b1; out_ready = 1'b1;
    step();
    play = 1'b0; loop_i = 1'b0;
    nb = 0; cyc = 0; prevv = 1'b0;
    while (nb < 4 && cyc < 200) begin
      n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL loop_no_done c%0d: got %b want 0", cyc, done6); end
      if (valid6 && !prevv) begin
        exp_a = (nb % 2 == 0) ? 18'h10 : 18'h11;
        n_cmp++; if (rom_addr6 !== exp_a) begin n_bad++; $display("FAIL loop_rom_addr b%0d: got %h want %h", nb, rom_addr6, exp_a); end
        n_cmp++; if (sample6 !== pcm(rom_mem[exp_a])) begin n_bad++; $display("FAIL loop_sample b%0d: got %h want %h", nb, sample6, pcm(rom_mem[exp_a])); end
        nb++;
      end
      prevv = valid6;
      step();
      cyc++;
    end
    if (nb < 4) begin
      n_cmp++; n_bad++;
      $display("FAIL loop_timeout: got %0d bytes want 4", nb);
    end
    n_cmp++; if (valid6 !== 1'b1) begin n_bad++; $display("FAIL loop_present: got %b want 1", valid6); end
    stop = 1'b1;
    step();
    stop = 1'b0; out_ready = 1'b0;
    n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL stop_valid: got %b want 0", valid6); end
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy6); end
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL stop_done: got %b want 0", done6); end
    n_cmp++; if (sample6 !== 16'h0) begin n_bad++; $display("FAIL stop_sample: got %h want 0000", sample6); end
    step();
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL stop_done_late: got %b want 0", done6); end
  endtask

  task automatic test_edge_cases();
    // zero length
    quiesce();
    play = 1'b1; start_addr = 18'h5; length = 18'd0;
    step();
    play = 1'b0;
    n_cmp++; if (done6 !== 1'b1) begin n_bad++; $display("FAIL len0_done: got %b want 1", done6); end
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL len0_busy: got %b want 0", busy6); end
    step();
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL len0_done_width: got %b want 0", done6); end
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL len0_busy_late: got %b want 0", busy6); end
    // play and stop together
    play = 1'b1; stop = 1'b1; start_addr = 18'h40; length = 18'd3;
    step();
    play = 1'b0; stop = 1'b0;
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL playstop_busy: got %b want 0", busy6); end
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL playstop_done: got %b want 0", done6); end
    step();
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL playstop_busy_late: got %b want 0", busy6); end
    // play while busy: one-byte clip at 0x20, then hammer play with another clip
    quiesce();
    play = 1'b1; start_addr = 18'h20; length = 18'd1; loop_i = 1'b0; out_ready = 1'b0;
    step();
    start_addr = 18'h50; length = 18'd3;
    repeat (5) step();
    n_cmp++; if (valid6 !== 1'b1) begin n_bad++; $display("FAIL busyplay_valid: got %b want 1", valid6); end
    n_cmp++; if (rom_addr6 !== 18'h20) begin n_bad++; $display("FAIL busyplay_rom_addr: got %h want 00020", rom_addr6); end
    n_cmp++; if (sample6 !== pcm(rom_mem[18'h20])) begin n_bad++; $display("FAIL busyplay_sample: got %h want %h", sample6, pcm(rom_mem[18'h20])); end
    play = 1'b0; out_ready = 1'b1;
    repeat (REP) step();
    out_ready = 1'b0;
    n_cmp++; if (done6 !== 1'b1) begin n_bad++; $display("FAIL busyplay_done: got %b want 1", done6); end
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL busyplay_busy: got %b want 0", busy6); end
  endtask

  task automatic test_reset_capture();
    quiesce();
    play = 1'b1; start_addr = 18'($urandom_range(1, 1000)); length = 18'd4; out_ready = 1'b1;
    step();
    play = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL rstcap_busy: got %b want 0", busy6); end
    n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL rstcap_done: got %b want 0", done6); end
    n_cmp++; if (valid6 !== 1'b0) begin n_bad++; $display("FAIL rstcap_valid: got %b want 0", valid6); end
    n_cmp++; if (sample6 !== 16'h0) begin n_bad++; $display("FAIL rstcap_sample: got %h want 0000", sample6); end
    n_cmp++; if (rom_addr6 !== 18'h0) begin n_bad++; $display("FAIL rstcap_rom_addr: got %h want 0", rom_addr6); end
    out_ready = 1'b0;
    step();
    run_clip(18'($urandom_range(0, DEPTH_TB - 1)), 18'd2, 2);
  endtask

  initial begin
    for (int i = 0; i < DEPTH_TB; i++) rom_mem[i] = 8'($urandom);
    test_reset();
    test_byte_timing();
    test_repeat_backpressure();
    test_loop();
    test_wrap();
    test_edge_cases();
    test_reset_capture();
    test_random_clips();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
